// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and the writeback entry type for the register file front end.
package rf_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = '0;
  typedef struct packed {
    logic valid;
    logic [RF_AW-1:0] dest;
    logic [RF_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_fwd_match.sv
// rf_fwd_match: youngest-match search over the pending writeback entries for one read port.
module rf_fwd_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH)
) (
  input  wb_entry_t          ent [DEPTH],
  input  logic [PW-1:0]      tail,
  input  logic [RF_AW-1:0]   sel,
  output logic               hit,
  output logic [RF_DW-1:0]   data
);
  // Walk from oldest (tail-DEPTH) to youngest (tail-1) so the youngest match wins.
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int k = DEPTH; k >= 1; k--)
      if (sel != RF_ZERO_REG && ent[PW'(tail - PW'(k))].valid && ent[PW'(tail - PW'(k))].dest == sel) begin
        hit = 1'b1;
        data = ent[PW'(tail - PW'(k))].data;
      end
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order writeback FIFO feeding the register file write port, with two forwarding lookups.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [AW-1:0]              wb_dest,
  input  logic [DW-1:0]              wb_data,
  output logic                       rf_en,
  output logic                       rf_write,
  output logic [AW-1:0]              rf_sel,
  output logic [DW-1:0]              rf_data,
  input  logic                       rf_grant,
  input  logic [AW-1:0]              fwd_sel_a,
  output logic                       fwd_hit_a,
  output logic [DW-1:0]              fwd_data_a,
  input  logic [AW-1:0]              fwd_sel_b,
  output logic                       fwd_hit_b,
  output logic [DW-1:0]              fwd_data_b,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t ent [DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop;
  assign wb_ready = count < CW'(DEPTH);
  assign idle = count == '0;
  assign rf_write = !idle;
  assign rf_en = rf_write;
  assign rf_sel = rf_write ? ent[head].dest : '0;
  assign rf_data = rf_write ? ent[head].data : '0;
  // Writes to register 0 complete the handshake but are dropped.
  assign push = wb_valid && wb_ready && wb_dest != RF_ZERO_REG;
  assign pop = rf_write && rf_grant;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) ent[head].valid <= 1'b0;
      if (push) ent[tail] <= '{valid: 1'b1, dest: wb_dest, data: wb_data};
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
    .ent(ent), .tail(tail), .sel(fwd_sel_a), .hit(fwd_hit_a), .data(fwd_data_a)
  );
  rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
    .ent(ent), .tail(tail), .sel(fwd_sel_b), .hit(fwd_hit_b), .data(fwd_data_b)
  );
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed stimulus checked against a queue-based model every cycle plus literal expectations.
module tb_rf_writeback_queue;
  logic clk = 0, rst = 0;
  logic wb_valid = 0, wb_ready, rf_en, rf_write, rf_grant = 0;
  logic [4:0] wb_dest = 0, rf_sel, fwd_sel_a = 0, fwd_sel_b = 0;
  logic [31:0] wb_data = 0, rf_data, fwd_data_a, fwd_data_b;
  logic fwd_hit_a, fwd_hit_b, idle;
  logic [2:0] count;
  int total = 0, passed = 0;

  rf_writeback_queue dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
    .wb_data(wb_data), .rf_en(rf_en), .rf_write(rf_write), .rf_sel(rf_sel), .rf_data(rf_data),
    .rf_grant(rf_grant), .fwd_sel_a(fwd_sel_a), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_sel_b(fwd_sel_b), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b), .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] d; logic [31:0] v; } ent_t;
  ent_t mq[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    else passed++;
  endtask

  function automatic void lookup(input logic [4:0] s, output logic h, output logic [31:0] d);
    h = 0;
    d = 0;
    if (s != 0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].d == s) begin
          h = 1;
          d = mq[i].v;
          break;
        end
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) mq.delete();
    else begin
      bit do_pop, do_push;
      do_pop = mq.size() != 0 && rf_grant;
      do_push = wb_valid && mq.size() < 4 && wb_dest != 0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ent_t'{wb_dest, wb_data});
    end

  always @(negedge clk) begin
    logic h;
    logic [31:0] d;
    chk("m_count", count, mq.size());
    chk("m_ready", wb_ready, mq.size() < 4);
    chk("m_idle", idle, mq.size() == 0);
    chk("m_write", {rf_en, rf_write}, {2{mq.size() != 0}});
    chk("m_sel", rf_sel, mq.size() != 0 ? mq[0].d : 5'd0);
    chk("m_data", rf_data, mq.size() != 0 ? mq[0].v : 32'd0);
    lookup(fwd_sel_a, h, d);
    chk("m_fwd_a", {fwd_hit_a, fwd_data_a}, {h, d});
    lookup(fwd_sel_b, h, d);
    chk("m_fwd_b", {fwd_hit_b, fwd_data_b}, {h, d});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] dst, input logic [31:0] dat, input logic g);
    wb_valid = v;
    wb_dest = dst;
    wb_data = dat;
    rf_grant = g;
  endtask

  initial begin
    tick();
    chk("rst_ready", wb_ready, 1);
    chk("rst_write", rf_write, 0);
    chk("rst_idle", idle, 1);
    chk("rst_sel", rf_sel, 0);
    tick();
    rst = 1;
    // single push, then look at head and forwarding
    fwd_sel_a = 5;
    drive(1, 5, 32'hDEADBEEF, 0);
    tick();
    chk("p1_write", rf_write, 1);
    chk("p1_sel", rf_sel, 5);
    chk("p1_data", rf_data, 32'hDEADBEEF);
    chk("p1_count", count, 1);
    chk("p1_hit_a", fwd_hit_a, 1);
    chk("p1_fwd_a", fwd_data_a, 32'hDEADBEEF);
    drive(0, 0, 0, 1);
    tick();
    chk("p1_idle", idle, 1);
    // fill, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'h100 + i, 0);
      tick();
    end
    chk("fill_count", count, 4);
    chk("fill_ready", wb_ready, 0);
    drive(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_sel", rf_sel, i);
      tick();
    end
    chk("drain_idle", idle, 1);
    chk("drain_write", rf_write, 0);
    // same-register writes, youngest forwards
    fwd_sel_b = 7;
    drive(1, 7, 32'h11, 0);
    tick();
    drive(1, 7, 32'h22, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("dup_fwd_b", fwd_data_b, 32'h22);
    drive(0, 0, 0, 1);
    tick();
    chk("dup_pop1_hit", fwd_hit_b, 1);
    chk("dup_pop1_fwd", fwd_data_b, 32'h22);
    tick();
    chk("dup_pop2_hit", fwd_hit_b, 0);
    // register 0 is dropped
    fwd_sel_a = 0;
    drive(1, 0, 32'hFFFF, 0);
    chk("z_ready", wb_ready, 1);
    tick();
    chk("z_count", count, 0);
    chk("z_write", rf_write, 0);
    chk("z_hit", fwd_hit_a, 0);
    // full with simultaneous push and pop, then wrap
    fwd_sel_a = 10;
    fwd_sel_b = 19;
    for (int i = 8; i <= 11; i++) begin
      drive(1, 5'(i), 32'h200 + i, 0);
      tick();
    end
    drive(1, 12, 32'h20C, 1);
    chk("full_ready", wb_ready, 0);
    tick();
    chk("full_count", count, 3);
    chk("full_sel", rf_sel, 9);
    drive(1, 13, 32'h20D, 1);
    chk("refill_ready", wb_ready, 1);
    tick();
    chk("both_count", count, 3);
    chk("both_sel", rf_sel, 10);
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(14 + i), 32'h300 + i, 1);
      tick();
      chk("wrap_count", count, 3);
    end
    chk("wrap_sel", rf_sel, 19);
    chk("wrap_data", rf_data, 32'h305);
    drive(0, 0, 0, 1);
    repeat (3) tick();
    chk("wrap_idle", idle, 1);
    // async reset mid-cycle with pending entries
    fwd_sel_a = 4;
    fwd_sel_b = 5;
    for (int i = 3; i <= 5; i++) begin
      drive(1, 5'(i), 32'h400 + i, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("pre_rst_hit", fwd_hit_a, 1);
    #2 rst = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_write", rf_write, 0);
    chk("arst_hit", {fwd_hit_a, fwd_hit_b}, 0);
    tick();
    rst = 1;
    fwd_sel_a = 20;
    drive(1, 20, 32'hABC, 0);
    tick();
    chk("post_sel", rf_sel, 20);
    chk("post_data", rf_data, 32'hABC);
    chk("post_count", count, 1);
    drive(0, 0, 0, 1);
    tick();
    chk("post_idle", idle, 1);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
